// File: rtl/piso_tx_pkg.sv
// rtl/piso_tx_pkg.sv - shared types, defaults and parity helper for piso_tx_arbiter
package piso_tx_pkg;

    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    // Even parity bit: makes the total count of ones (word + bit) even.
    function automatic logic even_parity(input logic [63:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/piso_rr_arbiter.sv
// rtl/piso_rr_arbiter.sv - combinational round-robin pick starting after the last winner
module piso_rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [IDX_W-1:0] idx;

    // Walk from the farthest candidate back to last+1 so the nearest active request wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        for (int i = NREQ; i >= 1; i--) begin
            idx = IDX_W'((int'(last) + i) % NREQ);
            if (req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/piso_tx_arbiter.sv
// rtl/piso_tx_arbiter.sv - round-robin shared PISO shifter; PISO_TX_PARITY_EN appends an even-parity bit
module piso_tx_arbiter
    import piso_tx_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*WIDTH-1:0]    data,
    input  logic                     shift_en,
    output logic [NREQ-1:0]          ack,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     serial_out,
    output logic                     frame_valid,
    output logic                     busy
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NREQ - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]   bitcnt_q, bitcnt_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]    ack_q, ack_d;
`ifdef PISO_TX_PARITY_EN
    logic               parity_q, parity_d;
`endif

    logic               gnt_valid;
    logic [IDX_W-1:0]   gnt_idx;
    logic [WIDTH-1:0]   words [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_words
        assign words[g] = data[g*WIDTH +: WIDTH];
    end

    piso_rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req       (req),
        .last      (last_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // State register; reset returns to IDLE and drops any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state and datapath: capture in IDLE, shift on shift_en, exit after the last bit.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        last_d   = last_q;
        grant_d  = grant_q;
        ack_d    = '0;
`ifdef PISO_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    shift_d        = words[gnt_idx];
                    bitcnt_d       = '0;
                    last_d         = gnt_idx;
                    grant_d        = gnt_idx;
                    ack_d[gnt_idx] = 1'b1;
`ifdef PISO_TX_PARITY_EN
                    parity_d       = even_parity(64'(words[gnt_idx]));
`endif
                    state_d        = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (shift_en) begin
                    shift_d  = {1'b0, shift_q[WIDTH-1:1]};
                    bitcnt_d = bitcnt_q + CNT_W'(1);
                    if (bitcnt_q == LAST_BIT) begin
`ifdef PISO_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_IDLE;
`endif
                    end
                end
            end
`ifdef PISO_TX_PARITY_EN
            ST_PARITY: begin
                if (shift_en) state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath registers; the pointer resets so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q  <= '0;
            bitcnt_q <= '0;
            last_q   <= LAST_RST;
            grant_q  <= '0;
            ack_q    <= '0;
`ifdef PISO_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            last_q   <= last_d;
            grant_q  <= grant_d;
            ack_q    <= ack_d;
`ifdef PISO_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Line driver: data bit while shifting, parity bit in PARITY, zero when idle.
    always_comb begin
        serial_out = 1'b0;
        case (state_q)
            ST_SHIFT:  serial_out = shift_q[0];
`ifdef PISO_TX_PARITY_EN
            ST_PARITY: serial_out = parity_q;
`endif
            default:   serial_out = 1'b0;
        endcase
    end

    assign frame_valid = (state_q != ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign ack         = ack_q;
    assign grant_id    = grant_q;

endmodule

// File: tb/tb_piso_tx_arbiter.sv
// tb/tb_piso_tx_arbiter.sv - self-checking bench for piso_tx_arbiter with a queue-based frame model
module tb_piso_tx_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;
`ifdef PISO_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] data;
    logic        shift_en;
    logic [3:0]  ack;
    logic [1:0]  grant_id;
    logic        serial_out;
    logic        frame_valid;
    logic        busy;

    int errors = 0;
    int checks = 0;

    // Reference model: a frame is a queue of bits still to appear on the line.
    bit         m_idle;
    bit         m_q[$];
    int         m_last;
    int         m_grant;
    logic [3:0] m_ack;

    always #5 clk = ~clk;

    piso_tx_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .data        (data),
        .shift_en    (shift_en),
        .ack         (ack),
        .grant_id    (grant_id),
        .serial_out  (serial_out),
        .frame_valid (frame_valid),
        .busy        (busy)
    );

    task automatic model_reset();
        m_idle  = 1'b1;
        m_q.delete();
        m_last  = NREQ - 1;
        m_grant = 0;
        m_ack   = '0;
    endtask

    // Advance the model with the current inputs, then move to the next negedge.
    task automatic step();
        if (rst) begin
            model_reset();
        end else if (m_idle) begin
            m_ack = '0;
            for (int i = 1; i <= NREQ; i++) begin
                int         c;
                logic [3:0] w;
                c = (m_last + i) % NREQ;
                if (req[c]) begin
                    w = data[c*WIDTH +: WIDTH];
                    for (int k = 0; k < WIDTH; k++) m_q.push_back(w[k]);
                    if (PB == 1) m_q.push_back(^w);
                    m_ack[c] = 1'b1;
                    m_last   = c;
                    m_grant  = c;
                    m_idle   = 1'b0;
                    break;
                end
            end
        end else begin
            m_ack = '0;
            if (shift_en) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_idle = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; data = 16'($urandom); shift_en = 1'b1;
        for (int n = 0; n < 2; n++) begin
            step();
            checks++;
            if ({ack, grant_id, serial_out, frame_valid, busy} !== 9'b0) begin
                errors++;
                $display("FAIL reset_outputs cyc=%0d got ack=%b gid=%0d so=%b fv=%b busy=%b want all 0",
                         n, ack, grant_id, serial_out, frame_valid, busy);
            end
        end
        rst = 1'b0; req = 4'b0000;
        step();
    endtask

    task automatic test_single_frame();
        logic e [5];
        e = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        data = 16'($urandom); data[7:4] = 4'b1011; req = 4'b0010; shift_en = 1'b1;
        step();
        checks++;
        if ({ack, grant_id} !== {4'b0010, 2'd1}) begin
            errors++;
            $display("FAIL single_grant got ack=%b gid=%0d want ack=0010 gid=1", ack, grant_id);
        end
        req = 4'b0000;
        for (int k = 0; k < WIDTH + PB; k++) begin
            checks++;
            if ({serial_out, frame_valid, busy, ack} !== {e[k], 1'b1, 1'b1, (k == 0) ? 4'b0010 : 4'b0000}) begin
                errors++;
                $display("FAIL single_bit%0d got so=%b fv=%b busy=%b ack=%b want so=%b fv=1 busy=1",
                         k, serial_out, frame_valid, busy, ack, e[k]);
            end
            step();
        end
        checks++;
        if ({serial_out, frame_valid, busy, ack} !== 7'b0) begin
            errors++;
            $display("FAIL single_idle got so=%b fv=%b busy=%b ack=%b want all 0",
                     serial_out, frame_valid, busy, ack);
        end
    endtask

    task automatic test_fairness();
        int ord [4];
        ord = '{0, 2, 0, 2};
        rst = 1'b1; step(); rst = 1'b0;
        data = 16'($urandom); req = 4'b0101; shift_en = 1'b1;
        for (int f = 0; f < 4; f++) begin
            checks++;
            if ({busy, ack} !== 5'b0) begin
                errors++;
                $display("FAIL fair_idle%0d got busy=%b ack=%b want 0", f, busy, ack);
            end
            step();
            checks++;
            if ({ack, grant_id} !== {4'b0001 << ord[f], 2'(ord[f])}) begin
                errors++;
                $display("FAIL fair_grant%0d got ack=%b gid=%0d want gid=%0d", f, ack, grant_id, ord[f]);
            end
            repeat (WIDTH + PB) step();
        end
        req = 4'b0000;
        step();
    endtask

    task automatic test_stall();
        logic en [7];
        logic e  [7];
        en = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        e  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        data = 16'($urandom); data[11:8] = 4'b0110; req = 4'b0100; shift_en = 1'b1;
        step();
        checks++;
        if ({ack, grant_id} !== {4'b0100, 2'd2}) begin
            errors++;
            $display("FAIL stall_grant got ack=%b gid=%0d want ack=0100 gid=2", ack, grant_id);
        end
        req = 4'b0000;
        for (int k = 0; k < 6 + PB; k++) begin
            checks++;
            if ({serial_out, frame_valid} !== {e[k], 1'b1}) begin
                errors++;
                $display("FAIL stall_cyc%0d got so=%b fv=%b want so=%b fv=1", k, serial_out, frame_valid, e[k]);
            end
            shift_en = en[k];
            step();
        end
        checks++;
        if ({frame_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL stall_end got fv=%b busy=%b want 0 0", frame_valid, busy);
        end
        shift_en = 1'b1;
    endtask

    task automatic test_reset_mid_frame();
        logic [3:0] w;
        w = 4'($urandom);
        data = 16'($urandom); data[3:0] = w; req = 4'b0001; shift_en = 1'b1;
        step();
        req = 4'b0000;
        step(); step();
        checks++;
        if ({serial_out, frame_valid} !== {w[2], 1'b1}) begin
            errors++;
            $display("FAIL midrst_bit2 got so=%b fv=%b want so=%b fv=1", serial_out, frame_valid, w[2]);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({ack, grant_id, serial_out, frame_valid, busy} !== 9'b0) begin
            errors++;
            $display("FAIL midrst_outputs got ack=%b gid=%0d so=%b fv=%b busy=%b want all 0",
                     ack, grant_id, serial_out, frame_valid, busy);
        end
        req = 4'b1000;
        step();
        checks++;
        if ({ack, grant_id} !== {4'b1000, 2'd3}) begin
            errors++;
            $display("FAIL midrst_regrant got ack=%b gid=%0d want ack=1000 gid=3", ack, grant_id);
        end
        req = 4'b0000;
        repeat (WIDTH + PB) step();
        step();
        checks++;
        if ({busy, ack} !== 5'b0) begin
            errors++;
            $display("FAIL midrst_no_resend got busy=%b ack=%b want 0", busy, ack);
        end
    endtask

`ifdef PISO_TX_PARITY_EN
    task automatic test_parity();
        logic e [5];
        e = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        rst = 1'b1; step(); rst = 1'b0;
        data = 16'($urandom); data[3:0] = 4'b0111; req = 4'b0001; shift_en = 1'b1;
        step();
        req = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({serial_out, frame_valid} !== {e[k], 1'b1}) begin
                errors++;
                $display("FAIL parity_bit%0d got so=%b fv=%b want so=%b fv=1", k, serial_out, frame_valid, e[k]);
            end
            step();
        end
        checks++;
        if (frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL parity_end got fv=%b want 0", frame_valid);
        end
    endtask
`endif

    task automatic test_random();
        logic es;
        for (int n = 0; n < 3000; n++) begin
            es = m_idle ? 1'b0 : m_q[0];
            checks++;
            if ({ack, grant_id, serial_out, frame_valid, busy} !==
                {m_ack, 2'(m_grant), es, !m_idle, !m_idle}) begin
                errors++;
                $display("FAIL random cyc=%0d got ack=%b gid=%0d so=%b fv=%b busy=%b want ack=%b gid=%0d so=%b fv=%b",
                         n, ack, grant_id, serial_out, frame_valid, busy, m_ack, m_grant, es, !m_idle);
            end
            rst      = ($urandom_range(0, 299) == 0);
            shift_en = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (m_ack[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    data[i*WIDTH +: WIDTH] = 4'($urandom);
                end
            end
            step();
        end
        rst = 1'b0; req = 4'b0000; shift_en = 1'b1;
        repeat (10) step();
    endtask

    initial begin
        rst = 1'b1; req = 4'b0000; data = 16'h0; shift_en = 1'b1;
        model_reset();
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_fairness();
        test_stall();
        test_reset_mid_frame();
`ifdef PISO_TX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/piso_tx_arbiter.md
# piso_tx_arbiter

Shares one parallel-in/serial-out transmit shifter among `NREQ` requesters. Each requester presents a `WIDTH`-bit word. The block picks one requester round-robin, loads the word, shifts it out LSB-first with a stall control, and acknowledges the requester. It sits between the word-level producers and the single serial line, and it owns the shifter, bit counter and grant pointer.

## Interface
Reset is synchronous and active-high, on the `clk` rising edge; the reset port is `rst`.

Parameters:
- `NREQ`, default 4: number of requesters, ≥2.
- `WIDTH`, default 4: bits per word, ≥2.

Ports:
- `clk`  in  1  sole clock; all logic on its rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `req`  in  NREQ  per-requester request; held high until the matching `ack`.
- `data`  in  NREQ*WIDTH  flat words; requester i uses `data[i*WIDTH +: WIDTH]`; held stable while `req[i]` is high.
- `shift_en`  in  1  high: advance one bit per cycle; low: hold the current bit.
- `ack`  out  NREQ  one-hot, one-cycle pulse; the word has been captured.
- `grant_id`  out  $clog2(NREQ)  index of the requester whose frame is on the line.
- `serial_out`  out  1  current bit, equal to `shift_reg[0]`.
- `frame_valid`  out  1  high while `serial_out` carries a data or parity bit.
- `busy`  out  1  state is not IDLE.

## Operation
- The FSM has three states: IDLE, SHIFT, PARITY. PARITY exists only with the macro.
- **IDLE**
  - If `req` is non-zero, the arbiter picks a winner w, searching upward from `last+1` and wrapping at NREQ.
  - At the edge: `shift_reg <= data[w]`, `last <= w`, `grant_id <= w`, `bitcnt <= 0`, `ack[w] <= 1`, state → SHIFT.
  - If `req` is zero, nothing changes.
- **SHIFT**
  - With `shift_en` high: `shift_reg <= {1'b0, shift_reg[WIDTH-1:1]}` and `bitcnt++`.
  - With `shift_en` low: everything holds.
  - When `bitcnt == WIDTH-1` and `shift_en` is high, state → PARITY if the macro is enabled, otherwise → IDLE.
- **PARITY**
  - `serial_out` = even parity of the captured word, held until `shift_en` is high, then → IDLE.
- There are no back-to-back frames: IDLE always lasts at least one cycle between frames.
- `req` seen while busy is ignored until IDLE. `ack` never pulses outside the IDLE→SHIFT edge.
- On a frame exit, the grant pointer advances, so a continuously requesting source cannot starve the others.
- `serial_out` and `frame_valid` are 0 in IDLE.

## Timing
- Reset values:
  - `ack=0`, `grant_id=0`, `serial_out=0`, `frame_valid=0`, `busy=0`.
  - State IDLE, `last=NREQ-1`, so `req[0]` wins the first tie.
- With a winning `req` in IDLE during cycle T:
  - `ack` is high in T+1 only.
  - Bit k is on `serial_out` in cycle T+1+k, with no stalls.
  - Parity, if enabled, is in T+1+WIDTH.
  - IDLE resumes in T+1+WIDTH (T+2+WIDTH with parity).
- Each cycle of `shift_en` low extends the frame by exactly one cycle. A stall in the last-bit cycle delays the exit.
- `rst` mid-frame wins over every other event:
  - Next cycle all outputs are at reset values and the pointer is reset.
  - The acked word is dropped and is not re-sent.
- A requester whose `req` drops before `ack` (a protocol violation) is not arbitrated that cycle. The design tolerates it but the bench need not cover it.

## Configuration
- `PISO_TX_PARITY_EN` defined: PARITY state is present; frames are WIDTH+1 bits, with an even-parity bit after the MSB.
- Undefined: no PARITY state and no parity logic; frames are WIDTH bits.

## Structure
- Package `piso_tx_pkg` holds:
  - the state enum (`ST_IDLE`, `ST_SHIFT`, `ST_PARITY`);
  - default `NREQ` and `WIDTH` constants;
  - a parity function.
- Sub-module `piso_rr_arbiter`, purely combinational:
  - inputs `req` and `last`;
  - outputs `gnt_valid` and `gnt_idx`.
- The top holds the FSM, shifter, counter and registers.

## Test plan
1. Reset: assert `rst` for 2 cycles with `req=4'b1111` → `ack=0`, `serial_out=0`, `frame_valid=0`, `busy=0`, and no grant.
2. Single frame: `req[1]=1`, `data[1]=4'b1011`, `shift_en=1` → `ack=4'b0010` at T+1; `serial_out` 1,1,0,1 over T+1..T+4; `grant_id=1`; IDLE at T+5.
3. Fairness: `req[0]` and `req[2]` held, re-asserted after each ack → grant order 0,2,0,2, with one IDLE cycle between frames.
4. Stall: `shift_en=0` for 2 cycles during bit 1 of `4'b0110` → `serial_out=1` for 3 cycles; frame_valid lasts 6 cycles.
5. Reset mid-frame: `rst` during bit 2 → next cycle outputs are all 0; then `req[3]` alone → `ack[3]` and `grant_id=3` after one IDLE cycle.
6. Parity (with `PISO_TX_PARITY_EN`): `data[0]=4'b0111` → bits 1,1,1,0, then parity 1; `frame_valid` for 5 cycles.
